// File: rtl/score_pkg.sv
// Shared types for the scoreboard button control path.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } state_t;

    typedef enum logic {
        UP = 1'b0,
        DN = 1'b1
    } dir_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer for one button.
module btn_debounce #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw_i;
            sync2 <= sync1;
        end
    end

    // A sample that agrees with the accepted level throws away any partial count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            level_o <= 1'b0;
            rise_o  <= 1'b0;
        end else begin
            rise_o <= 1'b0;
            if (sync2 != level_o) begin
                if (cnt == CNT_W'(DB_CYCLES - 1)) begin
                    level_o <= sync2;
                    rise_o  <= sync2;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/score_button_ctrl.sv
// Turns the up/down/clear buttons into exclusive inc/dec/erase pulses with auto-repeat.
module score_button_ctrl
    import score_pkg::*;
#(
    parameter int DB_CYCLES   = 16,
    parameter int HOLD_CYCLES = 64,
    parameter int RPT_CYCLES  = 16,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic up_i,
    input  logic down_i,
    input  logic clear_i,
    output logic inc_o,
    output logic dec_o,
    output logic erase_o,
    output logic busy_o
);

    logic up_lvl, up_rise, down_lvl, down_rise, clear_lvl, clear_rise;

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_up (
        .clk(clk), .rst(rst), .raw_i(up_i), .level_o(up_lvl), .rise_o(up_rise)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_down (
        .clk(clk), .rst(rst), .raw_i(down_i), .level_o(down_lvl), .rise_o(down_rise)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_clear (
        .clk(clk), .rst(rst), .raw_i(clear_i), .level_o(clear_lvl), .rise_o(clear_rise)
    );

    state_t           state, next_state;
    dir_t             dir, next_dir;
    logic [CNT_W-1:0] timer, next_timer;
    logic             next_inc, next_dec, next_erase, next_busy;

    logic act_lvl, opp_lvl, timer_done;

    assign act_lvl    = (dir == UP) ? up_lvl : down_lvl;
    assign opp_lvl    = (dir == UP) ? down_lvl : up_lvl;
    assign timer_done = (state == HOLD) ? (timer == CNT_W'(HOLD_CYCLES - 1))
                                        : (timer == CNT_W'(RPT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            dir     <= UP;
            timer   <= '0;
            inc_o   <= 1'b0;
            dec_o   <= 1'b0;
            erase_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            state   <= next_state;
            dir     <= next_dir;
            timer   <= next_timer;
            inc_o   <= next_inc;
            dec_o   <= next_dec;
            erase_o <= next_erase;
            busy_o  <= next_busy;
        end
    end

    // The timer only advances while staying in HOLD/REPEAT, so every state entry starts it at zero.
    always_comb begin
        next_state = state;
        next_dir   = dir;
        next_timer = '0;
        if (clear_rise) begin
            next_state = LOCK;
        end else begin
            case (state)
                IDLE: begin
                    if (up_rise && !down_lvl) begin
                        next_state = HOLD;
                        next_dir   = UP;
                    end else if (down_rise && !up_lvl) begin
                        next_state = HOLD;
                        next_dir   = DN;
                    end else if (up_lvl && down_lvl) begin
                        next_state = LOCK;
                    end
                end
                HOLD, REPEAT: begin
                    if (!act_lvl) begin
                        next_state = IDLE;
                    end else if (opp_lvl) begin
                        next_state = LOCK;
                    end else if (timer_done) begin
                        next_state = REPEAT;
                    end else begin
                        next_timer = timer + 1'b1;
                    end
                end
                LOCK: begin
                    if (!up_lvl && !down_lvl && !clear_lvl) begin
                        next_state = IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        next_inc   = 1'b0;
        next_dec   = 1'b0;
        next_erase = 1'b0;
        next_busy  = (next_state != IDLE);
        if (clear_rise) begin
            next_erase = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (up_rise && !down_lvl) begin
                        next_inc = 1'b1;
                    end else if (down_rise && !up_lvl) begin
                        next_dec = 1'b1;
                    end
                end
                HOLD, REPEAT: begin
                    if (act_lvl && !opp_lvl && timer_done) begin
                        next_inc = (dir == UP);
                        next_dec = (dir == DN);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_score_button_ctrl.sv
// Self-checking bench: fixed vector table, corner-case sequences and random presses against a reference model.
module tb_score_button_ctrl;

    localparam int DB   = 4;
    localparam int HOLD = 8;
    localparam int RPT  = 3;

    logic clk = 1'b0;
    logic rst, up, down, clear;
    logic inc_o, dec_o, erase_o, busy_o;

    score_button_ctrl #(
        .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .RPT_CYCLES(RPT), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .up_i(up), .down_i(down), .clear_i(clear),
        .inc_o(inc_o), .dec_o(dec_o), .erase_o(erase_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int seq_start = 0;
    int busy_seen = 0;
    int inc_log[$];
    int dec_log[$];
    int erase_log[$];

    // Reference model: a button is accepted once its last DB synced samples all disagree with the accepted level.
    typedef enum {M_IDLE, M_TRACK, M_LOCKED} mode_t;
    bit          m_s1[3], m_s2[3], m_lvl[3], m_rise[3];
    bit [DB-1:0] m_win[3];
    int          m_fill[3];
    mode_t       m_mode;
    int          m_dir;
    int          m_fire_at;
    bit          m_inc, m_dec, m_erase, m_busy;

    typedef struct {
        logic up, down, clear;
        logic inc, dec, erase, busy;
    } vec_t;
    vec_t tbl[18];

    function automatic void model_reset();
        for (int b = 0; b < 3; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_rise[b] = 0;
            m_win[b] = '0; m_fill[b] = 0;
        end
        m_mode = M_IDLE; m_dir = 0; m_fire_at = 0;
        m_inc = 0; m_dec = 0; m_erase = 0; m_busy = 0;
    endfunction

    function automatic void model_step(input logic u, input logic d, input logic c);
        bit raw[3];
        raw[0] = u; raw[1] = d; raw[2] = c;
        m_inc = 0; m_dec = 0; m_erase = 0;
        if (m_rise[2]) begin
            m_erase = 1;
            m_mode  = M_LOCKED;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (m_rise[0] && !m_lvl[1]) begin
                        m_inc = 1; m_dir = 0; m_mode = M_TRACK; m_fire_at = cyc + HOLD;
                    end else if (m_rise[1] && !m_lvl[0]) begin
                        m_dec = 1; m_dir = 1; m_mode = M_TRACK; m_fire_at = cyc + HOLD;
                    end else if (m_lvl[0] && m_lvl[1]) begin
                        m_mode = M_LOCKED;
                    end
                end
                M_TRACK: begin
                    if (!m_lvl[m_dir]) m_mode = M_IDLE;
                    else if (m_lvl[1 - m_dir]) m_mode = M_LOCKED;
                    else if (cyc == m_fire_at) begin
                        if (m_dir == 0) m_inc = 1; else m_dec = 1;
                        m_fire_at = cyc + RPT;
                    end
                end
                M_LOCKED: begin
                    if (!m_lvl[0] && !m_lvl[1] && !m_lvl[2]) m_mode = M_IDLE;
                end
            endcase
        end
        m_busy = (m_mode != M_IDLE);
        for (int b = 0; b < 3; b++) begin
            m_win[b] = {m_win[b][DB-2:0], m_s2[b]};
            if (m_fill[b] < DB) m_fill[b]++;
            m_rise[b] = 0;
            if (m_fill[b] == DB && m_win[b] == {DB{~m_lvl[b]}}) begin
                m_lvl[b]  = ~m_lvl[b];
                m_rise[b] = m_lvl[b];
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_output();
        chk("inc", 32'(inc_o), 32'(m_inc));
        chk("dec", 32'(dec_o), 32'(m_dec));
        chk("erase", 32'(erase_o), 32'(m_erase));
        chk("busy", 32'(busy_o), 32'(m_busy));
        chk("exclusive", 32'((32'(inc_o) + 32'(dec_o) + 32'(erase_o)) <= 1), 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(up, down, clear);
        #1;
        check_output();
        if (inc_o === 1'b1) inc_log.push_back(cyc - seq_start);
        if (dec_o === 1'b1) dec_log.push_back(cyc - seq_start);
        if (erase_o === 1'b1) erase_log.push_back(cyc - seq_start);
        if (busy_o === 1'b1) busy_seen++;
        cyc++;
    endtask

    task automatic apply_stimulus(input logic u, input logic d, input logic c, input int n);
        up = u; down = d; clear = c;
        repeat (n) tick();
    endtask

    task automatic start_seq();
        seq_start = cyc;
        busy_seen = 0;
        inc_log.delete();
        dec_log.delete();
        erase_log.delete();
    endtask

    // Called just after a clock edge; asserts reset mid-cycle so the async clear is observable.
    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("async_rst_inc", 32'(inc_o), 32'd0);
        chk("async_rst_dec", 32'(dec_o), 32'd0);
        chk("async_rst_erase", 32'(erase_o), 32'd0);
        chk("async_rst_busy", 32'(busy_o), 32'd0);
        model_reset();
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int exp_hold[9];
        int len;
        exp_hold = '{6, 14, 17, 20, 23, 26, 29, 32, 35};

        for (int i = 0; i < 18; i++) begin
            tbl[i].up    = (i < 8);
            tbl[i].down  = 1'b0;
            tbl[i].clear = 1'b0;
            tbl[i].inc   = (i == 6);
            tbl[i].dec   = 1'b0;
            tbl[i].erase = 1'b0;
            tbl[i].busy  = (i >= 6 && i <= 13);
        end

        rst = 1'b1; up = 0; down = 0; clear = 0;
        model_reset();
        #1;
        chk("reset_inc", 32'(inc_o), 32'd0);
        chk("reset_dec", 32'(dec_o), 32'd0);
        chk("reset_erase", 32'(erase_o), 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        rst = 1'b0;
        apply_stimulus(0, 0, 0, 5);

        // Single short press: one inc pulse, released before the first repeat.
        start_seq();
        for (int i = 0; i < 18; i++) begin
            up = tbl[i].up; down = tbl[i].down; clear = tbl[i].clear;
            tick();
            chk("tbl_inc", 32'(inc_o), 32'(tbl[i].inc));
            chk("tbl_dec", 32'(dec_o), 32'(tbl[i].dec));
            chk("tbl_erase", 32'(erase_o), 32'(tbl[i].erase));
            chk("tbl_busy", 32'(busy_o), 32'(tbl[i].busy));
        end
        apply_stimulus(0, 0, 0, 10);

        // Glitches shorter than the debounce window are ignored.
        start_seq();
        apply_stimulus(1, 0, 0, 3);
        apply_stimulus(0, 0, 0, 5);
        for (int g = 0; g < 4; g++) begin
            apply_stimulus(1, 0, 0, 1);
            apply_stimulus(0, 0, 0, 1);
        end
        apply_stimulus(0, 0, 0, 10);
        chk("glitch_pulses", 32'(inc_log.size()), 32'd0);
        chk("glitch_busy", 32'(busy_seen), 32'd0);

        // Long hold: first pulse, hold delay, then steady auto-repeat.
        start_seq();
        apply_stimulus(1, 0, 0, 30);
        apply_stimulus(0, 0, 0, 15);
        chk("hold_count", 32'(inc_log.size()), 32'd9);
        for (int i = 0; i < 9; i++)
            if (i < inc_log.size()) chk("hold_cycle", 32'(inc_log[i]), 32'(exp_hold[i]));
        chk("hold_busy_end", 32'(busy_o), 32'd0);

        // Clear during a hold: one erase, then locked until everything is released.
        start_seq();
        apply_stimulus(1, 0, 0, 7);
        apply_stimulus(1, 0, 1, 33);
        apply_stimulus(0, 0, 0, 15);
        chk("clr_inc_count", 32'(inc_log.size()), 32'd1);
        chk("clr_erase_count", 32'(erase_log.size()), 32'd1);
        if (erase_log.size() > 0) chk("clr_erase_cycle", 32'(erase_log[0]), 32'd13);

        // Up and down together: locked, no pulses, then a clean down press.
        start_seq();
        apply_stimulus(1, 1, 0, 12);
        chk("both_busy", 32'(busy_o), 32'd1);
        apply_stimulus(0, 0, 0, 12);
        chk("both_pulses", 32'(inc_log.size() + dec_log.size()), 32'd0);
        chk("both_idle", 32'(busy_o), 32'd0);
        start_seq();
        apply_stimulus(0, 1, 0, 8);
        apply_stimulus(0, 0, 0, 15);
        chk("down_count", 32'(dec_log.size()), 32'd1);
        if (dec_log.size() > 0) chk("down_cycle", 32'(dec_log[0]), 32'd6);

        // Reset in the middle of auto-repeat with the button still held.
        start_seq();
        apply_stimulus(1, 0, 0, 19);
        apply_reset();
        start_seq();
        apply_stimulus(1, 0, 0, 10);
        chk("rst_first_inc", (inc_log.size() > 0) ? 32'(inc_log[0]) : 32'hFFFF_FFFF, 32'd6);
        apply_stimulus(0, 0, 0, 15);

        // Random press patterns against the model, with one reset thrown in.
        for (int s = 0; s < 60; s++) begin
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 40));
            apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 5) == 0), len);
            if (s == 30) apply_reset();
        end
        apply_stimulus(0, 0, 0, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
